// File: rtl/fixed_point_pkg.sv
// Shared fixed-point definitions for the divider and multiplier.
// Holds the default operand width, the fractional bit count (Q8.8 by default),
// the Q-format extreme values and the divider state encoding.
package fixed_point_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned FRAC_BITS  = 8;

  // Extreme representable values of the default Q-format.
  localparam logic [DATA_WIDTH-1:0] QMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] QMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StDiv  = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } div_state_e;

endpackage

// File: rtl/divider_if.sv
// Divider request/response bundle.
//   A, B          : signed fixed-point dividend / divisor (requester drives)
//   start         : request, honoured only while the divider is idle or done
//   result        : signed fixed-point quotient
//   overflow_flag : quotient out of range, or divide-by-zero
//   div_by_zero   : divisor was zero
//   finish        : result valid, held until the next accepted start
// master = requester side, slave = divider side.
interface divider_if #(
  parameter int unsigned DATA_WIDTH = fixed_point_pkg::DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic                  start;
  logic [DATA_WIDTH-1:0] result;
  logic                  overflow_flag;
  logic                  div_by_zero;
  logic                  finish;

  modport master (
    output A, B, start,
    input  result, overflow_flag, div_by_zero, finish
  );

  modport slave (
    input  A, B, start,
    output result, overflow_flag, div_by_zero, finish
  );
endinterface

// File: rtl/fp_sign_sat.sv
// Sign restore and range check for an unsigned quotient magnitude.
// Ports:
//   mag_i    : unsigned quotient magnitude (MAG_WIDTH bits)
//   neg_i    : quotient is negative
//   dbz_i    : divisor was zero; forces the clamp value and overflow
//   result_o : signed DATA_WIDTH-bit result
//   ovf_o    : magnitude outside the representable range
// Macro DIVIDER_SATURATE_EN: out-of-range results clamp to max/min; without it
// they wrap to the low DATA_WIDTH bits of the signed quotient.
module fp_sign_sat #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAG_WIDTH  = 24
) (
  input  logic [MAG_WIDTH-1:0]  mag_i,
  input  logic                  neg_i,
  input  logic                  dbz_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  ovf_o
);

  localparam logic [MAG_WIDTH-1:0] PosLimit =
      {{(MAG_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [MAG_WIDTH-1:0] NegLimit = PosLimit + 1'b1;
  localparam logic [DATA_WIDTH-1:0] MaxVal = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MinVal = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  always_comb begin
    // Low bits of the two's complement equal the low bits of the negated low bits.
    result_o = neg_i ? (~mag_i[DATA_WIDTH-1:0] + 1'b1) : mag_i[DATA_WIDTH-1:0];
    ovf_o    = 1'b0;
    if (dbz_i) begin
      ovf_o    = 1'b1;
      result_o = neg_i ? MinVal : MaxVal;
    end else begin
      ovf_o = neg_i ? (mag_i > NegLimit) : (mag_i > PosLimit);
`ifdef DIVIDER_SATURATE_EN
      if (ovf_o) begin
        result_o = neg_i ? MinVal : MaxVal;
      end
`endif
    end
  end

endmodule

// File: rtl/divider.sv
// Sequential signed fixed-point divider (restoring, one quotient bit per cycle).
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : asynchronous active-low reset
//   bus : divider_if slave (A, B, start in; result, overflow_flag,
//         div_by_zero, finish out)
// Flow: IDLE/DONE --start--> DIV (DATA_WIDTH+FRAC_BITS steps) --> FIX --> DONE.
// A zero divisor skips DIV. Operands are captured on acceptance.
// Macro DIVIDER_SATURATE_EN selects saturating instead of wrapping results.
module divider #(
  parameter int unsigned DATA_WIDTH = fixed_point_pkg::DATA_WIDTH,
  parameter int unsigned FRAC_BITS  = fixed_point_pkg::FRAC_BITS
) (
  input logic       clk,
  input logic       rst,
  divider_if.slave  bus
);
  import fixed_point_pkg::*;

  localparam int unsigned NumSteps = DATA_WIDTH + FRAC_BITS;
  localparam int unsigned CntW     = $clog2(NumSteps + 1);

  div_state_e            state_q;
  // Dividend bits shift out of the top while quotient bits shift in at the bottom.
  logic [NumSteps-1:0]   quo_q;
  logic [DATA_WIDTH-1:0] rem_q;
  logic [DATA_WIDTH-1:0] dvs_q;
  logic [CntW-1:0]       cnt_q;
  logic                  sign_q;
  logic                  zero_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  ovf_q;
  logic                  dbz_q;
  logic                  finish_q;

  logic [DATA_WIDTH-1:0] a_mag;
  logic [DATA_WIDTH-1:0] b_mag;
  logic [DATA_WIDTH:0]   rem_shift;
  logic [DATA_WIDTH-1:0] rem_sub;
  logic                  step_ge;
  logic [DATA_WIDTH-1:0] fix_result;
  logic                  fix_ovf;

  always_comb begin
    a_mag     = bus.A[DATA_WIDTH-1] ? (~bus.A + 1'b1) : bus.A;
    b_mag     = bus.B[DATA_WIDTH-1] ? (~bus.B + 1'b1) : bus.B;
    rem_shift = {rem_q, quo_q[NumSteps-1]};
    step_ge   = rem_shift >= {1'b0, dvs_q};
    // Only used when step_ge, so the difference always fits DATA_WIDTH bits.
    rem_sub   = rem_shift[DATA_WIDTH-1:0] - dvs_q;
  end

  fp_sign_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAG_WIDTH  (NumSteps)
  ) u_sign_sat (
    .mag_i    (quo_q),
    .neg_i    (sign_q),
    .dbz_i    (zero_q),
    .result_o (fix_result),
    .ovf_o    (fix_ovf)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            quo_q    <= {a_mag, {FRAC_BITS{1'b0}}};
            rem_q    <= '0;
            dvs_q    <= b_mag;
            cnt_q    <= CntW'(NumSteps);
            sign_q   <= bus.A[DATA_WIDTH-1] ^ bus.B[DATA_WIDTH-1];
            zero_q   <= (bus.B == '0);
            finish_q <= 1'b0;
            state_q  <= (bus.B == '0) ? StFix : StDiv;
          end
        end
        StDiv: begin
          rem_q <= step_ge ? rem_sub : rem_shift[DATA_WIDTH-1:0];
          quo_q <= {quo_q[NumSteps-2:0], step_ge};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          result_q <= fix_result;
          ovf_q    <= fix_ovf;
          dbz_q    <= zero_q;
          finish_q <= 1'b1;
          state_q  <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.result        = result_q;
  assign bus.overflow_flag = ovf_q;
  assign bus.div_by_zero   = dbz_q;
  assign bus.finish        = finish_q;

endmodule

// File: tb/tb_divider.sv
// Directed bench for the fixed-point divider: a vector table plus hand-written
// sequences for reset release, ignored re-start, output hold and mid-op reset.
`timescale 1ns/1ps
module tb_divider;
  import fixed_point_pkg::*;

  localparam int unsigned DW = 16;
`ifdef DIVIDER_SATURATE_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  divider_if #(.DATA_WIDTH(DW)) bus ();

  divider #(
    .DATA_WIDTH (DW),
    .FRAC_BITS  (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        ovf;
    logic        dbz;
    int          lat;
  } vec_t;

  localparam int NV = 15;
  vec_t v[NV];

  int n_checks = 0;
  int n_fail   = 0;
  int lat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present a request before the next edge, then scramble the operands so a
  // late re-capture would be visible.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A     = 16'h5A5A;
    bus.B     = 16'h0000;
  endtask

  // Counts rising edges until finish is seen; -1 if the budget runs out.
  task automatic wait_finish(input int budget, output int n);
    bit done;
    done = 1'b0;
    n    = 0;
    while (n < budget && !done) begin
      @(posedge clk);
      n++;
      #1;
      done = bus.finish;
    end
    if (!done) n = -1;
  endtask

  initial begin
    v[0]  = '{16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, 25};  // 3 / 2
    v[1]  = '{16'hFF00, 16'h0300, 16'hFFAB, 1'b0, 1'b0, 25};  // -1 / 3 truncates
    v[2]  = '{16'h7F00, 16'h0080, SatEn ? 16'h7FFF : 16'hFE00, 1'b1, 1'b0, 25};
    v[3]  = '{16'h0100, 16'h0000, QMAX,     1'b1, 1'b1, 1};   // 1 / 0
    v[4]  = '{16'hFF00, 16'h0000, QMIN,     1'b1, 1'b1, 1};   // -1 / 0
    v[5]  = '{16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0, 25};  // -128 / 1, at min
    v[6]  = '{16'h8000, 16'hFF00, SatEn ? 16'h7FFF : 16'h8000, 1'b1, 1'b0, 25};
    v[7]  = '{16'h7FFF, 16'h0100, 16'h7FFF, 1'b0, 1'b0, 25};  // at max
    v[8]  = '{16'h0000, 16'hFF00, 16'h0000, 1'b0, 1'b0, 25};  // 0 / -1
    v[9]  = '{16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0, 25};  // 1 / 3
    v[10] = '{16'hFD00, 16'hFE00, 16'h0180, 1'b0, 1'b0, 25};  // -3 / -2
    v[11] = '{16'hC000, 16'h0080, 16'h8000, 1'b0, 1'b0, 25};  // -64 / 0.5 = -128
    v[12] = '{16'hBF00, 16'h0080, SatEn ? 16'h8000 : 16'h7E00, 1'b1, 1'b0, 25};
    v[13] = '{16'hFFFF, 16'h0200, 16'h0000, 1'b0, 1'b0, 25};  // tiny negative -> 0
    v[14] = '{16'h0100, 16'hFFFF, SatEn ? 16'h8000 : 16'h0000, 1'b1, 1'b0, 25};

    rst       = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset result", bus.result, 0);
    check("reset ovf", bus.overflow_flag, 0);
    check("reset dbz", bus.div_by_zero, 0);
    check("reset finish", bus.finish, 0);

    // Start presented together with reset release: accepted on the next edge.
    @(negedge clk);
    rst       = 1'b1;
    bus.A     = 16'h0300;
    bus.B     = 16'h0200;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_finish(40, lat);
    check("first latency", lat, 25);
    check("first result", bus.result, 16'h0180);

    // Outputs hold in DONE.
    repeat (5) @(posedge clk);
    #1;
    check("hold result", bus.result, 16'h0180);
    check("hold finish", bus.finish, 1);

    for (int i = 0; i < NV; i++) begin
      start_op(v[i].a, v[i].b);
      check($sformatf("v%0d finish clear", i), bus.finish, 0);
      wait_finish(40, lat);
      check($sformatf("v%0d latency", i), lat, v[i].lat);
      check($sformatf("v%0d result", i), bus.result, v[i].res);
      check($sformatf("v%0d ovf", i), bus.overflow_flag, v[i].ovf);
      check($sformatf("v%0d dbz", i), bus.div_by_zero, v[i].dbz);
    end

    // Re-pulsed start at edge 5 of an operation must be ignored.
    start_op(16'h0300, 16'h0200);
    repeat (5) @(negedge clk);
    bus.A     = 16'h0100;
    bus.B     = 16'h0100;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_finish(40, lat);
    check("restart latency", lat, 20);
    check("restart result", bus.result, 16'h0180);

    // Leave non-zero flags behind, then reset at edge 10 of the next operation.
    start_op(16'h0100, 16'h0000);
    wait_finish(40, lat);
    check("pre-reset dbz", bus.div_by_zero, 1);
    start_op(16'h0300, 16'h0200);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midop result", bus.result, 0);
    check("midop ovf", bus.overflow_flag, 0);
    check("midop dbz", bus.div_by_zero, 0);
    check("midop finish", bus.finish, 0);
    @(negedge clk);
    rst = 1'b1;
    start_op(16'hFF00, 16'h0300);
    wait_finish(40, lat);
    check("post-reset latency", lat, 25);
    check("post-reset result", bus.result, 16'hFFAB);
    check("post-reset ovf", bus.overflow_flag, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter: DATA_WIDTH, default 16, operand/result width in bits.
REQ-002 Parameter: FRAC_BITS, default 8, fractional bits of the signed fixed-point format (Q8.8 at defaults).
REQ-003 Port: clk, input, 1, single clock; all state changes on rising edge.
REQ-004 Port: rst, input, 1, reset, asynchronous and active-low.
REQ-005 Port: A, input, DATA_WIDTH, signed dividend.
REQ-006 Port: B, input, DATA_WIDTH, signed divisor.
REQ-007 Port: start, input, 1, request; sampled only in IDLE or DONE.
REQ-008 Port: result, output, DATA_WIDTH, signed quotient A/B in the same fixed-point format.
REQ-009 Port: overflow_flag, output, 1, quotient out of range or divide-by-zero.
REQ-010 Port: div_by_zero, output, 1, B was zero.
REQ-011 Port: finish, output, 1, result valid; held until the next accepted start.

Function
REQ-012 States: IDLE, DIV, FIX, DONE.
REQ-013 IDLE/DONE with start=1: capture |A|<<FRAC_BITS, |B|, sign=A[msb]^B[msb]; clear finish; load counter=DATA_WIDTH+FRAC_BITS; go to DIV (or FIX if B==0).
REQ-014 DIV: one restoring-division step per cycle, shifting one quotient bit in MSB-first; the last step, at counter==1, goes to FIX.
REQ-015 FIX: apply sign (two's complement), range-check, register result/overflow_flag/div_by_zero, assert finish, go to DONE.
REQ-016 Latency: finish rises on the 25th rising edge after the edge that accepted start (DATA_WIDTH+FRAC_BITS+1); divide-by-zero: on the 1st edge after acceptance.
REQ-017 Quotient truncates toward zero; remainder discarded.
REQ-018 Range: positive magnitude >2^(DATA_WIDTH-1)-1 or negative magnitude >2^(DATA_WIDTH-1) sets overflow_flag=1.
REQ-019 B==0: div_by_zero=1, overflow_flag=1, result=0x7FFF if A>=0 else 0x8000.
REQ-020 start during DIV or FIX is ignored; the operation in progress completes unaffected.
REQ-021 Operands captured at acceptance; A/B changes afterwards have no effect.
REQ-022 result, overflow_flag, div_by_zero hold their values in DONE and through IDLE until the next FIX.

Reset
REQ-023 rst low, at any time including mid-operation: state=IDLE, result=0, overflow_flag=0, div_by_zero=0, finish=0, counter and internal registers cleared.
REQ-024 The first start is accepted on the first rising edge after rst deasserts.

Configuration
REQ-025 Macro DIVIDER_SATURATE_EN defined: an out-of-range result saturates to 0x7FFF (positive) or 0x8000 (negative).
REQ-026 Macro absent: an out-of-range result is the low DATA_WIDTH bits of the signed quotient (wraps); overflow_flag behaviour is unchanged; the divide-by-zero result per REQ-019 is unchanged.

Structure
REQ-027 Package fixed_point_pkg holds DATA_WIDTH, FRAC_BITS, the Q-format min/max constants and the divider state enum; it is shared with the multiplier.
REQ-028 One combinational sub-module, fp_sign_sat: sign restore plus range check/saturation; instantiated in FIX.

Verification
REQ-029 A=0x0300, B=0x0200 (3.0/2.0) -> result=0x0180, overflow_flag=0, div_by_zero=0, finish high 25 edges after acceptance.
REQ-030 A=0xFF00, B=0x0300 (-1/3) -> result=0xFFAB (truncation toward zero), overflow_flag=0.
REQ-031 A=0x7F00, B=0x0080 (127/0.5) -> overflow_flag=1; result=0x7FFF with DIVIDER_SATURATE_EN, 0xFE00 without.
REQ-032 A=0x0100, B=0x0000 -> div_by_zero=1, overflow_flag=1, result=0x7FFF, finish 1 edge after acceptance.
REQ-033 A=0x0300, B=0x0200 accepted, then start re-pulsed with A=0x0100, B=0x0100 at edge 5 -> second request ignored; result=0x0180.
REQ-034 rst low at edge 10 of an operation -> all outputs 0 immediately; a new start after release completes normally.
